// File: rtl/keypad_scan_controller.sv
// rtl/keypad_scan_controller.sv - keypad synchronizer, debouncer, note event sequencer, octave/mode registers
//
// Purpose:
//   Synchronizes and debounces the raw note keys and the three control keys.
//   Resolves the highest held note key, then turns changes of that key into
//   note-off / note-on events on a valid/ready handshake. The octave-up,
//   octave-down and mode keys step the octave and mode registers.
//
// Ports:
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   keys_raw     raw note keys, active-high, asynchronous to clk
//   oct_up_raw   raw octave-up key
//   oct_down_raw raw octave-down key
//   mode_raw     raw mode key
//   note_ready   downstream accepts the presented event
//   note_valid   event presented
//   note_on      1 = note-on, 0 = note-off (meaningful with note_valid)
//   note_code    note code of the event (1..NUM_KEYS)
//   active_code  last note-on accepted downstream, 0 if none
//   octave       current octave, 0..OCT_MAX
//   mode         current mode, 0..NUM_MODES-1
module keypad_scan_controller #(
  parameter int NUM_KEYS        = 17,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OCT_MAX         = 7,
  parameter int OCT_RESET       = 4,
  parameter int NUM_MODES       = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_KEYS-1:0] keys_raw,
  input  logic                oct_up_raw,
  input  logic                oct_down_raw,
  input  logic                mode_raw,
  input  logic                note_ready,
  output logic                note_valid,
  output logic                note_on,
  output logic [4:0]          note_code,
  output logic [4:0]          active_code,
  output logic [2:0]          octave,
  output logic [1:0]          mode
);

  localparam int VW     = NUM_KEYS + 3;
  localparam int CW     = $clog2(DEBOUNCE_CYCLES);
  localparam int BIT_UP = NUM_KEYS;
  localparam int BIT_DN = NUM_KEYS + 1;
  localparam int BIT_MD = NUM_KEYS + 2;

  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  // The stable vector is written on the same edge the counter reaches
  // CNT_MAX, which gives a raw-to-stable latency of 2 + DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_OFF = 2'd1,
    SEND_ON  = 2'd2
  } state_t;

  logic [VW-1:0] raw_vec;
  logic [VW-1:0] sync1;
  logic [VW-1:0] sync2;
  logic [VW-1:0] cand;
  logic [VW-1:0] stable;
  logic [VW-1:0] stable_d;
  logic [CW-1:0] cnt;
  logic [4:0]    stable_code;
  logic          up_rise;
  logic          dn_rise;
  logic          md_rise;

  state_t        state;
  state_t        state_n;
  logic          valid_n;
  logic          on_n;
  logic [4:0]    code_n;
  logic [4:0]    active_n;

  assign raw_vec = {mode_raw, oct_down_raw, oct_up_raw, keys_raw};

  // Two-flop synchronizer on every raw input.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_vec;
      sync2 <= sync1;
    end
  end

  // One shared counter: any bit change restarts the whole vector's settle time.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cand     <= '0;
      stable   <= '0;
      stable_d <= '0;
      cnt      <= '0;
    end else begin
      stable_d <= stable;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
        if (cnt >= CNT_LOAD) begin
          stable <= cand;
        end
      end
    end
  end

  // Highest held note key wins.
  always_comb begin
    stable_code = 5'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (stable[i]) begin
        stable_code = 5'(i + 1);
      end
    end
  end

  assign up_rise = stable[BIT_UP] & ~stable_d[BIT_UP];
  assign dn_rise = stable[BIT_DN] & ~stable_d[BIT_DN];
  assign md_rise = stable[BIT_MD] & ~stable_d[BIT_MD];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      octave <= 3'(OCT_RESET);
      mode   <= 2'd0;
    end else begin
      // Simultaneous up and down presses cancel.
      if (up_rise && !dn_rise) begin
        if (octave != 3'(OCT_MAX)) begin
          octave <= octave + 3'd1;
        end
      end else if (dn_rise && !up_rise) begin
        if (octave != 3'd0) begin
          octave <= octave - 3'd1;
        end
      end
      if (md_rise) begin
        mode <= (mode == 2'(NUM_MODES - 1)) ? 2'd0 : mode + 2'd1;
      end
    end
  end

  // Event FSM: all handshake outputs are registered alongside the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      note_valid  <= 1'b0;
      note_on     <= 1'b0;
      note_code   <= 5'd0;
      active_code <= 5'd0;
    end else begin
      state       <= state_n;
      note_valid  <= valid_n;
      note_on     <= on_n;
      note_code   <= code_n;
      active_code <= active_n;
    end
  end

  always_comb begin
    state_n  = state;
    valid_n  = note_valid;
    on_n     = note_on;
    code_n   = note_code;
    active_n = active_code;
    case (state)
      IDLE: begin
        // A held note must be released before a different one is started.
        if (stable_code != active_code) begin
          valid_n = 1'b1;
          if (active_code != 5'd0) begin
            state_n = SEND_OFF;
            on_n    = 1'b0;
            code_n  = active_code;
          end else begin
            state_n = SEND_ON;
            on_n    = 1'b1;
            code_n  = stable_code;
          end
        end
      end
      SEND_OFF: begin
        if (note_ready) begin
          state_n  = IDLE;
          valid_n  = 1'b0;
          active_n = 5'd0;
        end
      end
      SEND_ON: begin
        if (note_ready) begin
          state_n  = IDLE;
          valid_n  = 1'b0;
          active_n = note_code;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb/tb_keypad_scan_controller.sv - scoreboard bench for keypad_scan_controller
module tb_keypad_scan_controller;

  localparam int NK = 17;
  localparam int D  = 4;

  logic          clk;
  logic          n_rst;
  logic [NK-1:0] keys_raw;
  logic          oct_up_raw;
  logic          oct_down_raw;
  logic          mode_raw;
  logic          note_ready;
  logic          note_valid;
  logic          note_on;
  logic [4:0]    note_code;
  logic [4:0]    active_code;
  logic [2:0]    octave;
  logic [1:0]    mode;

  keypad_scan_controller dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .keys_raw     (keys_raw),
    .oct_up_raw   (oct_up_raw),
    .oct_down_raw (oct_down_raw),
    .mode_raw     (mode_raw),
    .note_ready   (note_ready),
    .note_valid   (note_valid),
    .note_on      (note_on),
    .note_code    (note_code),
    .active_code  (active_code),
    .octave       (octave),
    .mode         (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) begin
        $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Reference model: window of raw samples, event-level handshake model.
  logic [19:0] hist [0:D+1];
  logic [19:0] m_stable;
  logic [19:0] m_stable_d;
  logic [19:0] m_rise;
  int          m_active;
  int          m_oct;
  int          m_mode;
  bit          m_pend;
  bit          m_pon;
  int          m_pcode;
  int          m_sc;
  bit          m_eq;
  int          exp_q[$];   // expected events: on*100 + code
  int          log_q[$];   // events accepted from the DUT
  int          ex[$];

  function automatic int code_of(input logic [19:0] v);
    int c;
    c = 0;
    for (int i = 0; i < NK; i++) begin
      if (v[i]) c = i + 1;
    end
    return c;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i <= D + 1; i++) hist[i] = '0;
      m_stable   = '0;
      m_stable_d = '0;
      m_active   = 0;
      m_oct      = 4;
      m_mode     = 0;
      m_pend     = 1'b0;
      m_pon      = 1'b0;
      m_pcode    = 0;
      exp_q.delete();
    end else begin
      m_rise = m_stable & ~m_stable_d;
      m_sc   = code_of(m_stable);
      if (m_rise[17] && !m_rise[18]) m_oct = (m_oct < 7) ? m_oct + 1 : 7;
      else if (m_rise[18] && !m_rise[17]) m_oct = (m_oct > 0) ? m_oct - 1 : 0;
      if (m_rise[19]) m_mode = (m_mode + 1) % 4;
      if (m_pend) begin
        if (note_ready) begin
          m_active = m_pon ? m_pcode : 0;
          m_pend   = 1'b0;
        end
      end else if (m_sc != m_active) begin
        m_pend = 1'b1;
        if (m_active != 0) begin
          m_pon   = 1'b0;
          m_pcode = m_active;
        end else begin
          m_pon   = 1'b1;
          m_pcode = m_sc;
        end
        exp_q.push_back(m_pon * 100 + m_pcode);
      end
      for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {mode_raw, oct_down_raw, oct_up_raw, keys_raw};
      m_stable_d = m_stable;
      m_eq = 1'b1;
      for (int i = 3; i <= D + 1; i++) begin
        if (hist[i] != hist[2]) m_eq = 1'b0;
      end
      if (m_eq) m_stable = hist[2];
    end
  end

  // Monitor: per-cycle state comparison and scoreboard pop on handshake.
  always @(negedge clk) begin
    chk("note_valid", note_valid, m_pend);
    chk("active_code", active_code, m_active);
    chk("octave", octave, m_oct);
    chk("mode", mode, m_mode);
    if (m_pend) begin
      chk("note_code", note_code, m_pcode);
      chk("note_on", note_on, m_pon);
    end
    if (n_rst && note_valid && note_ready) begin
      log_q.push_back(note_on * 100 + note_code);
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        chk("sb_event", note_on * 100 + note_code, exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, log_q.size(), ex.size());
    for (int i = 0; i < log_q.size() && i < ex.size(); i++) begin
      chk(name, log_q[i], ex[i]);
    end
    log_q.delete();
    ex.delete();
  endtask

  task automatic press(input int which);
    if (which == 0) oct_up_raw = 1'b1;
    else if (which == 1) oct_down_raw = 1'b1;
    else if (which == 2) mode_raw = 1'b1;
    else begin
      oct_up_raw   = 1'b1;
      oct_down_raw = 1'b1;
    end
    step(8);
    oct_up_raw   = 1'b0;
    oct_down_raw = 1'b0;
    mode_raw     = 1'b0;
    step(8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int r;
  int hold;

  initial begin
    n_rst        = 1'b0;
    keys_raw     = '0;
    oct_up_raw   = 1'b0;
    oct_down_raw = 1'b0;
    mode_raw     = 1'b0;
    note_ready   = 1'b0;
    step(3);
    n_rst = 1'b1;
    chk("rst_valid", note_valid, 0);
    chk("rst_active", active_code, 0);
    chk("rst_octave", octave, 4);
    chk("rst_mode", mode, 0);
    step(50);
    check_log("idle_events");

    // Single key press and release.
    note_ready  = 1'b1;
    keys_raw[0] = 1'b1;
    step(10);
    chk("key0_active", active_code, 1);
    keys_raw = '0;
    step(12);
    chk("key0_released", active_code, 0);
    ex.push_back(101);
    ex.push_back(1);
    check_log("key0");

    // Two keys: highest wins; dropping it falls back to the lower key.
    keys_raw[3]  = 1'b1;
    keys_raw[16] = 1'b1;
    step(12);
    chk("pri_active", active_code, 17);
    keys_raw[16] = 1'b0;
    step(16);
    chk("pri_fallback", active_code, 4);
    keys_raw = '0;
    step(12);
    ex.push_back(117);
    ex.push_back(17);
    ex.push_back(104);
    ex.push_back(4);
    check_log("priority");

    // Backpressure: event held stable, key change handled afterwards.
    note_ready  = 1'b0;
    keys_raw[5] = 1'b1;
    step(8);
    for (int i = 0; i < 20; i++) begin
      chk("stall_valid", note_valid, 1);
      chk("stall_code", note_code, 6);
      if (i == 5) begin
        keys_raw    = '0;
        keys_raw[9] = 1'b1;
      end
      step(1);
    end
    note_ready = 1'b1;
    step(20);
    keys_raw = '0;
    step(12);
    ex.push_back(106);
    ex.push_back(6);
    ex.push_back(110);
    ex.push_back(10);
    check_log("stall");

    // Short pulse and single-cycle glitches never reach the stable vector.
    keys_raw[2] = 1'b1;
    step(2);
    keys_raw[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      keys_raw[2] = ~keys_raw[2];
      step(1);
    end
    keys_raw = '0;
    step(15);
    check_log("glitch");

    // Asynchronous reset while an on-event is presented.
    note_ready  = 1'b0;
    keys_raw[7] = 1'b1;
    step(9);
    chk("pre_rst_valid", note_valid, 1);
    n_rst = 1'b0;
    #1;
    chk("async_rst_valid", note_valid, 0);
    chk("async_rst_active", active_code, 0);
    keys_raw   = '0;
    note_ready = 1'b1;
    step(3);
    n_rst = 1'b1;
    step(15);
    check_log("reset_event");

    // Octave and mode keys.
    for (int i = 0; i < 5; i++) begin
      press(0);
      chk("oct_up", octave, (i + 5 > 7) ? 7 : i + 5);
    end
    press(3);
    chk("oct_both", octave, 7);
    for (int i = 0; i < 9; i++) begin
      press(1);
      chk("oct_down", octave, (6 - i < 0) ? 0 : 6 - i);
    end
    for (int i = 0; i < 5; i++) begin
      press(2);
      chk("mode_step", mode, (i + 1) % 4);
    end

    // Randomized phase checked by the model and scoreboard.
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 9);
      keys_raw = '0;
      if (r >= 3) keys_raw[$urandom_range(0, NK - 1)] = 1'b1;
      if (r >= 8) keys_raw[$urandom_range(0, NK - 1)] = 1'b1;
      oct_up_raw   = ($urandom_range(0, 9) == 0);
      oct_down_raw = ($urandom_range(0, 9) == 0);
      mode_raw     = ($urandom_range(0, 9) == 0);
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) begin
        note_ready = ($urandom_range(0, 3) != 0);
        step(1);
      end
    end
    keys_raw     = '0;
    oct_up_raw   = 1'b0;
    oct_down_raw = 1'b0;
    mode_raw     = 1'b0;
    note_ready   = 1'b1;
    step(30);
    chk("sb_drained", exp_q.size(), 0);
    chk("final_active", active_code, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan_controller.md
Name: keypad_scan_controller

Overview:
- Sequencing front end for the keypad path.
- Synchronizes and debounces 17 raw note keys plus the octave-up, octave-down and mode keys.
- Priority-resolves the held note key and converts key changes into a stream of note-on/note-off events on a valid/ready handshake to the voice/oscillator stage.
- Maintains the octave and mode registers driven by the control keys.

Parameters:
- NUM_KEYS, 17: number of note keys; note code = key index + 1; code 0 = no key.
- DEBOUNCE_CYCLES, 4: consecutive identical synchronized samples required before the stable vector updates (>= 2).
- OCT_MAX, 7: highest octave value; lowest is 0.
- OCT_RESET, 4: octave value after reset.
- NUM_MODES, 4: number of modes; mode wraps modulo NUM_MODES.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset, asynchronous, active-low.
- keys_raw  input  NUM_KEYS  raw note keys, active-high, asynchronous to clk.
- oct_up_raw  input  1  raw octave-up key, active-high.
- oct_down_raw  input  1  raw octave-down key, active-high.
- mode_raw  input  1  raw mode key, active-high.
- note_ready  input  1  downstream accepts the current event.
- note_valid  output  1  event presented.
- note_on  output  1  1 = note-on, 0 = note-off; valid only with note_valid.
- note_code  output  5  note code of the event (1..NUM_KEYS).
- active_code  output  5  last note-on accepted downstream, 0 if none.
- octave  output  3  current octave, 0..OCT_MAX.
- mode  output  2  current mode, 0..NUM_MODES-1.

Behaviour:
- Reset: the design has one clock, clk. Reset n_rst is asynchronous, active-low. While reset is asserted:
  - note_valid=0, note_on=0, note_code=0, active_code=0, octave=OCT_RESET, mode=0.
  - Synchronizers, candidate and stable vectors, and debounce counter are all 0.
  - FSM is in IDLE.
  - Reset mid-event drops the pending event; no note-off is generated after reset.
- Synchronizer: all 20 raw inputs pass through a 2-flop synchronizer.
- Debounce: one shared counter covers the 20-bit synchronized vector.
  - If the sampled vector differs from the candidate: candidate <= sample, counter <= 0.
  - Otherwise the counter increments, saturating.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the sample still equal to the candidate, stable <= candidate.
  - Raw-to-stable latency is 2 + DEBOUNCE_CYCLES cycles.
  - Toggling faster than this never reaches the stable vector.
- Priority: stable_code = index+1 of the highest set stable note bit; 0 if none set. Multiple held keys resolve to the highest index.
- Event FSM, states IDLE, SEND_OFF, SEND_ON:
  - IDLE, stable_code == active_code: stay.
  - IDLE, stable_code != active_code and active_code != 0: go to SEND_OFF with note_code=active_code, note_on=0.
  - IDLE, stable_code != active_code and active_code == 0: go to SEND_ON with note_code=stable_code (latched), note_on=1.
  - note_valid is registered and equals 1 exactly in SEND_OFF and SEND_ON. First valid cycle is one clock after the stable_code change.
  - SEND_OFF with note_ready: active_code <= 0, return to IDLE.
  - SEND_ON with note_ready: active_code <= latched code, return to IDLE.
  - After a completed event, IDLE re-evaluates, so a key change A->B produces off(A), one IDLE cycle, then on(B).
  - While valid: note_code and note_on stay stable until accepted.
  - stable_code changes during a send do not alter the in-flight event; they are handled on the next IDLE evaluation. Intermediate codes can be skipped; only the latest stable_code is pursued.
  - note_ready while note_valid=0 is ignored.
- Octave: acts on the rising edge of the stable oct_up / oct_down bits.
  - Up: octave+1, saturating at OCT_MAX.
  - Down: octave-1, saturating at 0.
  - Both edges in the same cycle: no change.
  - Updates the next cycle, independent of the FSM. An in-flight event is unaffected.
- Mode: on the rising edge of the stable mode bit, mode <= (mode+1) mod NUM_MODES. Independent of the FSM and the octave logic.

Test Plan:
- Reset, no keys, 50 cycles -> note_valid=0, active_code=0, octave=4, mode=0 throughout.
- Press key 0 held 10 cycles, note_ready=1 -> one event on, code 1, valid exactly 1 cycle; active_code=1. Release -> one off, code 1; active_code=0.
- Keys 3 and 16 held together -> on, code 17. Drop key 16 while key 3 is still held -> off 17, then on 4.
- Key 5 pressed, note_ready=0 for 20 cycles -> valid=1 and code 6 stable for all 20 cycles. Key changes to 9 meanwhile. Raise ready -> on 6 accepted, then off 6, then on 10.
- Key pulse of 2 cycles, then 1-cycle glitches -> no events. Reset asserted asynchronously during SEND_ON -> valid drops to 0 immediately, active_code=0.
- oct_up pressed 5 times -> octave 5, 6, 7, 7, 7. Both octave keys pressed simultaneously -> unchanged. oct_down 9 times -> saturates at 0. mode pressed 5 times -> 1, 2, 3, 0, 1.
